// File: rtl/x_mem_arb.sv
// rtl/x_mem_arb.sv - single-port sample memory arbiter: playback priority, host starvation guard
// Owns all memory strobes and routes each read return to the requester that issued it.
module x_mem_arb #(
    parameter int AW         = 11,
    parameter int DW         = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_gnt,
    output logic          o_host_rvalid,
    output logic [DW-1:0] o_host_rdata,
    input  logic          i_play_req,
    input  logic [AW-1:0] i_play_addr,
    output logic          o_play_gnt,
    output logic          o_play_rvalid,
    output logic [DW-1:0] o_play_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q, starve_d;
    logic          force_host;
    logic          host_take, play_take;

    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    // Read tag travels with the access that is on the memory bus this cycle.
    logic          rtag_vld_q, rtag_host_q;
    logic          host_rvalid_q, play_rvalid_q;
    logic [DW-1:0] host_rdata_q, play_rdata_q;

    assign force_host = (starve_q == STARVE_LIM);
    assign play_take  = i_play_req & ~force_host;
    assign host_take  = i_host_req & (~i_play_req | force_host);

    always_comb begin
        starve_d = starve_q;
        if (!i_host_req || host_take) begin
            starve_d = '0;
        end else if (play_take && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            starve_q      <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rtag_vld_q    <= 1'b0;
            rtag_host_q   <= 1'b0;
            host_rvalid_q <= 1'b0;
            play_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            play_rdata_q  <= '0;
        end else begin
            starve_q    <= starve_d;
            mem_en_q    <= host_take | play_take;
            mem_we_q    <= host_take & i_host_we;
            if (host_take) begin
                mem_addr_q  <= i_host_addr;
                mem_wdata_q <= i_host_wdata;
            end else if (play_take) begin
                mem_addr_q  <= i_play_addr;
            end
            rtag_vld_q    <= (host_take & ~i_host_we) | play_take;
            rtag_host_q   <= host_take;
            host_rvalid_q <= rtag_vld_q & rtag_host_q;
            play_rvalid_q <= rtag_vld_q & ~rtag_host_q;
            if (rtag_vld_q && rtag_host_q) begin
                host_rdata_q <= i_mem_rdata;
            end
            if (rtag_vld_q && !rtag_host_q) begin
                play_rdata_q <= i_mem_rdata;
            end
        end
    end

    assign o_host_gnt    = host_take;
    assign o_play_gnt    = play_take;
    assign o_mem_en      = mem_en_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_host_rvalid = host_rvalid_q;
    assign o_host_rdata  = host_rdata_q;
    assign o_play_rvalid = play_rvalid_q;
    assign o_play_rdata  = play_rdata_q;

endmodule

// File: tb/tb_x_mem_arb.sv
// tb/tb_x_mem_arb.sv - scoreboard bench for x_mem_arb
// Expected read data comes from a reference memory updated at host write grants.
module tb_x_mem_arb;

    localparam int AW = 11;
    localparam int DW = 6;

    logic          i_clk = 1'b0;
    logic          i_nrst;
    logic          i_host_req, i_host_we;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_wdata;
    logic          o_host_gnt, o_host_rvalid;
    logic [DW-1:0] o_host_rdata;
    logic          i_play_req;
    logic [AW-1:0] i_play_addr;
    logic          o_play_gnt, o_play_rvalid;
    logic [DW-1:0] o_play_rdata;
    logic          o_mem_en, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;

    x_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_host_req(i_host_req), .i_host_we(i_host_we),
        .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
        .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid), .o_host_rdata(o_host_rdata),
        .i_play_req(i_play_req), .i_play_addr(i_play_addr),
        .o_play_gnt(o_play_gnt), .o_play_rvalid(o_play_rvalid), .o_play_rdata(o_play_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[5:0] ^ {1'b0, a[10:6]};
    endfunction

    // Memory macro model: registered inputs from the arbiter, read data follows the address.
    logic [DW-1:0] mem [2048];
    bit mem_init = 1'b0;
    always @(posedge i_clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(AW'(i));
            mem_init <= 1'b1;
        end else if (o_mem_en && o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
        end
    end
    assign i_mem_rdata = mem[o_mem_addr];

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          host_q[$];
    exp_t          play_q[$];
    logic [DW-1:0] ref_mem [2048];
    logic [DW-1:0] host_hold, play_hold;
    int            cyc;
    int            n_checks;
    int            n_pass;

    // Scoreboard step at the sampling point: pop returns, then push new grants.
    task automatic sb_step();
        exp_t e;
        if (!i_nrst) begin
            host_q.delete();
            play_q.delete();
            host_hold = '0;
            play_hold = '0;
        end else begin
            if (o_host_rvalid) begin
                n_checks++;
                if (host_q.size() == 0) begin
                    $display("FAIL host_rvalid_unexpected: got rvalid at cycle %0d required none", cyc);
                end else begin
                    e = host_q.pop_front();
                    if (o_host_rdata !== e.data || cyc !== e.cyc)
                        $display("FAIL host_return: got data %h cycle %0d required data %h cycle %0d",
                                 o_host_rdata, cyc, e.data, e.cyc);
                    else n_pass++;
                    host_hold = e.data;
                    n_checks++;
                    if (o_play_rdata !== play_hold)
                        $display("FAIL play_rdata_hold: got %h required %h", o_play_rdata, play_hold);
                    else n_pass++;
                end
            end
            if (o_play_rvalid) begin
                n_checks++;
                if (play_q.size() == 0) begin
                    $display("FAIL play_rvalid_unexpected: got rvalid at cycle %0d required none", cyc);
                end else begin
                    e = play_q.pop_front();
                    if (o_play_rdata !== e.data || cyc !== e.cyc)
                        $display("FAIL play_return: got data %h cycle %0d required data %h cycle %0d",
                                 o_play_rdata, cyc, e.data, e.cyc);
                    else n_pass++;
                    play_hold = e.data;
                    n_checks++;
                    if (o_host_rdata !== host_hold)
                        $display("FAIL host_rdata_hold: got %h required %h", o_host_rdata, host_hold);
                    else n_pass++;
                end
            end
            if (i_host_req && o_host_gnt) begin
                if (i_host_we) ref_mem[i_host_addr] = i_host_wdata;
                else host_q.push_back('{data: ref_mem[i_host_addr], cyc: cyc + 2});
            end
            if (i_play_req && o_play_gnt)
                play_q.push_back('{data: ref_mem[i_play_addr], cyc: cyc + 2});
        end
    endtask

    task automatic drive(input logic h_req, input logic h_we, input logic [AW-1:0] h_addr,
                         input logic [DW-1:0] h_wdata, input logic p_req, input logic [AW-1:0] p_addr);
        @(posedge i_clk);
        #1;
        cyc++;
        i_host_req   = h_req;
        i_host_we    = h_we;
        i_host_addr  = h_addr;
        i_host_wdata = h_wdata;
        i_play_req   = p_req;
        i_play_addr  = p_addr;
        @(negedge i_clk);
        sb_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (host_q.size() != 0 || play_q.size() != 0)
            $display("FAIL %s_drained: got %0d host %0d play pending required 0 0",
                     name, host_q.size(), play_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        i_host_req = 1'b0; i_host_we = 1'b0; i_host_addr = '0; i_host_wdata = '0;
        i_play_req = 1'b0; i_play_addr = '0;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if ({o_host_gnt, o_host_rvalid, o_host_rdata, o_play_gnt, o_play_rvalid, o_play_rdata,
             o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== '0)
            $display("FAIL reset_outputs: got gnt %b%b en %b we %b addr %h wdata %h hr %h pr %h required all 0",
                     o_host_gnt, o_play_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
                     o_host_rdata, o_play_rdata);
        else n_pass++;
        @(posedge i_clk);
        #1;
        i_nrst = 1'b1;
    endtask

    task automatic test_host_write_read();
        drive(1'b1, 1'b1, 11'h123, 6'h2A, 1'b0, '0);
        n_checks++;
        if (o_host_gnt !== 1'b1) $display("FAIL host_wr_gnt: got %b required 1", o_host_gnt);
        else n_pass++;
        drive(1'b1, 1'b0, 11'h123, 6'h00, 1'b0, '0);
        n_checks++;
        if (o_host_gnt !== 1'b1 || o_mem_we !== 1'b1 || o_mem_wdata !== 6'h2A)
            $display("FAIL host_rd_gnt: got gnt %b we %b wdata %h required 1 1 2a",
                     o_host_gnt, o_mem_we, o_mem_wdata);
        else n_pass++;
        idle(3);
        n_checks++;
        if (o_host_rdata !== 6'h2A) $display("FAIL host_rd_data: got %h required 2a", o_host_rdata);
        else n_pass++;
        check_drained("host_rw");
    endtask

    task automatic test_play_burst();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(k));
            else idle(1);
            n_checks++;
            if (o_play_gnt !== (k < 4) || o_mem_en !== (k >= 1 && k <= 4))
                $display("FAIL play_burst_%0d: got gnt %b en %b required %b %b",
                         k, o_play_gnt, o_mem_en, (k < 4), (k >= 1 && k <= 4));
            else n_pass++;
        end
        idle(2);
        check_drained("play_burst");
    endtask

    task automatic test_starvation();
        int hosts;
        hosts = 0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, AW'(11'h200 + i / 5), DW'(i / 5), 1'b1, AW'(11'h040 + i));
            n_checks++;
            if (o_host_gnt !== (i % 5 == 4) || o_play_gnt !== (i % 5 != 4))
                $display("FAIL starve_pattern_%0d: got host %b play %b required %b %b",
                         i, o_host_gnt, o_play_gnt, (i % 5 == 4), (i % 5 != 4));
            else n_pass++;
            if (o_host_gnt) hosts++;
        end
        n_checks++;
        if (hosts !== 3) $display("FAIL starve_host_count: got %0d required 3", hosts);
        else n_pass++;
        idle(3);
        check_drained("starve");
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 11'h050, '0, 1'b1, 11'h051);
        n_checks++;
        if (o_play_gnt !== 1'b1 || o_host_gnt !== 1'b0)
            $display("FAIL simul_first: got play %b host %b required 1 0", o_play_gnt, o_host_gnt);
        else n_pass++;
        drive(1'b1, 1'b0, 11'h050, '0, 1'b0, '0);
        n_checks++;
        if (o_play_gnt !== 1'b0 || o_host_gnt !== 1'b1)
            $display("FAIL simul_second: got play %b host %b required 0 1", o_play_gnt, o_host_gnt);
        else n_pass++;
        idle(3);
        check_drained("simul");
    endtask

    task automatic test_reset_inflight();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 11'h7FF);
        n_checks++;
        if (o_play_gnt !== 1'b1) $display("FAIL inflight_gnt: got %b required 1", o_play_gnt);
        else n_pass++;
        @(posedge i_clk);
        #1;
        cyc++;
        i_nrst = 1'b0;
        i_play_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            sb_step();
            n_checks++;
            if (o_play_rvalid !== 1'b0) $display("FAIL inflight_rst_rvalid: got %b required 0", o_play_rvalid);
            else n_pass++;
            @(posedge i_clk);
            #1;
            cyc++;
        end
        i_nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_checks++;
            if (o_play_rvalid !== 1'b0) $display("FAIL inflight_post_rvalid: got %b required 0", o_play_rvalid);
            else n_pass++;
        end
        drive(1'b1, 1'b0, 11'h7FF, '0, 1'b0, '0);
        n_checks++;
        if (o_host_gnt !== 1'b1) $display("FAIL post_rst_host_gnt: got %b required 1", o_host_gnt);
        else n_pass++;
        drive(1'b1, 1'b0, 11'h010, '0, 1'b1, 11'h020);
        n_checks++;
        if (o_play_gnt !== 1'b1 || o_host_gnt !== 1'b0)
            $display("FAIL post_rst_priority: got play %b host %b required 1 0", o_play_gnt, o_host_gnt);
        else n_pass++;
        drive(1'b1, 1'b0, 11'h010, '0, 1'b0, '0);
        idle(3);
        check_drained("inflight");
    endtask

    task automatic test_interleave();
        drive(1'b1, 1'b0, 11'h123, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 11'h001);
        drive(1'b1, 1'b0, 11'h010, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 11'h7FF);
        drive(1'b1, 1'b0, 11'h200, '0, 1'b0, '0);
        idle(3);
        n_checks++;
        if (o_host_rdata !== ref_mem[11'h200] || o_play_rdata !== ref_mem[11'h7FF])
            $display("FAIL interleave_final: got host %h play %h required %h %h",
                     o_host_rdata, o_play_rdata, ref_mem[11'h200], ref_mem[11'h7FF]);
        else n_pass++;
        check_drained("interleave");
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_pass = 0;
        host_hold = '0;
        play_hold = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = pat(AW'(i));
        test_reset();
        test_host_write_read();
        test_play_burst();
        test_starvation();
        test_simultaneous();
        test_reset_inflight();
        test_interleave();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
